// File: rtl/gold_seq_gen.sv
// Gold-code chip source: two Fibonacci LFSRs, programmable phase offset on
// sequence 2, selectable output mode and a valid/ready chip stream.
module gold_seq_gen #(
  parameter int             DEG   = 6,
  parameter logic [DEG-1:0] POLY1 = 6'b000011,
  parameter logic [DEG-1:0] POLY2 = 6'b100111,
  parameter logic [DEG-1:0] SEED  = {DEG{1'b1}}
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  input  logic [DEG-1:0] cfg_shift_i,
  input  logic [1:0]     cfg_mode_i,
  input  logic           stop_i,
  output logic           m_tvalid_o,
  input  logic           m_tready_i,
  output logic           m_tdata_o,
  output logic           m_tlast_o,
  output logic [DEG-1:0] chip_idx_o,
  output logic           busy_o
);

  // Period N = 2^DEG-1 is the all-ones value; last chip index is N-1.
  localparam logic [DEG-1:0] N_VAL   = {DEG{1'b1}};
  localparam logic [DEG-1:0] IDX_LST = N_VAL - DEG'(1);
  localparam logic [DEG-1:0] ONE     = DEG'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [DEG-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [DEG-1:0] shift_q, shift_d;
  logic [DEG-1:0] idx_q, idx_d;
  logic [1:0]     mode_q, mode_d;
  logic           gold;

  function automatic logic [DEG-1:0] lfsr_step(input logic [DEG-1:0] s,
                                               input logic [DEG-1:0] poly);
    return {^(s & poly), s[DEG-1:1]};
  endfunction

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s1_q    <= SEED;
      s2_q    <= SEED;
      shift_q <= '0;
      idx_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  assign gold = s1_q[0] ^ s2_q[0];

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    cfg_ready_o = 1'b0;
    m_tvalid_o  = 1'b0;
    m_tdata_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          s1_d    = SEED;
          s2_d    = SEED;
          mode_d  = cfg_mode_i;
          shift_d = (cfg_shift_i == N_VAL) ? '0 : cfg_shift_i;
          idx_d   = '0;
          state_d = (shift_d != '0) ? ST_SEED : ST_RUN;
        end
      end
      ST_SEED: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else begin
          s2_d    = lfsr_step(s2_q, POLY2);
          shift_d = shift_q - ONE;
          if (shift_q == ONE) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        m_tvalid_o = 1'b1;
        case (mode_q)
          2'b00:   m_tdata_o = gold;
          2'b01:   m_tdata_o = s1_q[0];
          2'b10:   m_tdata_o = s2_q[0];
          default: m_tdata_o = ~gold;
        endcase
        // A handshake coinciding with stop still completes; IDLE then holds.
        if (m_tready_i) begin
          s1_d  = lfsr_step(s1_q, POLY1);
          s2_d  = lfsr_step(s2_q, POLY2);
          idx_d = (idx_q == IDX_LST) ? '0 : idx_q + ONE;
        end
        if (stop_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_tlast_o  = (state_q == ST_RUN) && (idx_q == IDX_LST);
  assign chip_idx_o = idx_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: doc/gold_seq_gen.md
# gold_seq_gen

Parametrised Gold-code chip source with run-time code selection: two DEG-bit Fibonacci LFSRs, a programmable phase offset on the second sequence, selectable output mode, and a valid/ready chip stream with end-of-period marker. It replaces the fixed 63-chip generator in the spreading chain. It feeds the modulator and correlator reference paths, which may apply backpressure.

## Interface
- DEG, 6, LFSR degree; period N = 2^DEG − 1.
- POLY1, 6'b000011, DEG-bit feedback tap mask, sequence 1.
- POLY2, 6'b100111, DEG-bit feedback tap mask, sequence 2.
- SEED, all ones, DEG-bit load value for both LFSRs; must be non-zero.

- clkin  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid_i  in  1  configuration request.
- cfg_ready_o  out  1  high only in IDLE.
- cfg_shift_i  in  DEG  phase offset of sequence 2, in chips.
- cfg_mode_i  in  2  00 gold, 01 seq1 only, 10 seq2 only, 11 inverted gold.
- stop_i  in  1  abort run, return to IDLE.
- m_tvalid_o  out  1  chip valid.
- m_tready_i  in  1  consumer ready.
- m_tdata_o  out  1  chip.
- m_tlast_o  out  1  last chip of period (index N−1).
- chip_idx_o  out  DEG  index of current chip, 0..N−1.
- busy_o  out  1  state != IDLE.

## Operation
- LFSR step: out = s[0]; fb = ^(s & POLY); s_next = {fb, s[DEG-1:1]}.
- FSM states: IDLE, SEED, RUN.
- IDLE:
  - cfg_ready_o = 1.
  - On cfg_valid_i:
    - load s1 = s2 = SEED.
    - latch mode.
    - shift_cnt = cfg_shift_i, with value N treated as 0.
    - chip_idx = 0.
    - next state is SEED if shift_cnt != 0, else RUN.
- SEED:
  - s2 steps once per cycle; s1 holds.
  - shift_cnt decrements each cycle.
  - Leave to RUN in the cycle shift_cnt reaches 1, i.e. after exactly shift_cnt steps.
- RUN:
  - m_tvalid_o = 1.
  - m_tdata_o by mode: s1[0]^s2[0], s1[0], s2[0], or ~(s1[0]^s2[0]).
  - On m_tvalid_o && m_tready_i:
    - both LFSRs step.
    - chip_idx increments, wrapping from N−1 to 0.
  - Without a handshake, all state holds, so data is stable under backpressure.
- m_tlast_o = RUN && chip_idx == N−1.
- Period wrap needs no reload: the LFSR state returns to its period start naturally after N steps.
- stop_i has priority over everything in SEED and RUN:
  - next state is IDLE.
  - a handshake in the same cycle still completes, but the LFSRs are not stepped afterwards.
- cfg_valid_i outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE.
  - s1 = s2 = SEED.
  - chip_idx 0, shift_cnt 0, mode 00.
  - Outputs: cfg_ready_o 1, m_tvalid_o 0, m_tdata_o 0, m_tlast_o 0, busy_o 0.
- m_tdata_o and m_tlast_o are forced to 0 outside RUN.
- Configuration accepted at edge T with shift k: the first m_tvalid_o is high in cycle T+1+k.
- Throughput: one chip per cycle when m_tready_i is held high.
- stop_i sampled at edge T: m_tvalid_o is low from cycle T+1; cfg_ready_o is high from T+1.
- Reset asserted mid-SEED or mid-RUN: outputs reach their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, seq1-only stream:
  - Stimulus: reset, then cfg mode 01, shift 0, m_tready_i = 1.
  - Required: m_tvalid_o high one cycle after the configuration handshake.
  - Required: first chips 1,1,1,1,1,1,0.
  - Required: m_tlast_o only on chip 62; chip 63 equals chip 0.
- Gold with offset:
  - Stimulus: mode 00, shift 5.
  - Required: tvalid arrives 6 cycles after the handshake.
  - Required: 126 chips match a reference model of s1 XOR s2, with s2 pre-advanced 5 steps.
  - Required: both periods are identical.
- Backpressure:
  - Stimulus: toggle m_tready_i randomly.
  - Required: m_tdata_o, m_tlast_o and chip_idx_o are stable while tready = 0.
  - Required: the accepted chip sequence is identical to the no-backpressure run.
- Modes and boundary shifts:
  - Mode 11 gives the bitwise inverse of mode 00.
  - Mode 10 gives seq2.
  - Shift 63 behaves as shift 0.
  - Shift 62: tvalid arrives at T+63.
- Abort and reconfigure:
  - Stimulus: stop_i in SEED, then stop_i in RUN at chip 10.
  - Required: IDLE next cycle in both cases.
  - Required: a new configuration restarts from chip_idx 0 with fresh seeds.
  - Required: cfg_valid_i pulsed during RUN has no effect.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges in RUN.
  - Required: m_tvalid_o falls immediately; all outputs take their reset values.
